// File: rtl/sector_sweep_ctrl.sv
// Main sequencer for the LED sector display: IDLE -> SWEEP -> DONE.
// Optional DONE auto-return to IDLE is built when SECTOR_DONE_TIMEOUT_EN is defined.
module sector_sweep_ctrl #(
    parameter int NUM_GROUPS        = 4,
    parameter int SECTORS_PER_GROUP = 8,
    parameter int STEP_CYCLES       = 25000000,
    parameter int DONE_TIMEOUT      = 250000000,
    localparam int GW  = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
    localparam int SW  = (SECTORS_PER_GROUP > 1) ? $clog2(SECTORS_PER_GROUP) : 1,
    localparam int TW  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         change_sector_group,
    output logic [1:0]                   main_state,
    output logic [GW-1:0]                group_idx,
    output logic [SW-1:0]                sector_idx,
    output logic [SECTORS_PER_GROUP-1:0] led,
    output logic                         sweep_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SWEEP = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam logic [TW-1:0] STEP_LAST   = TW'(STEP_CYCLES - 1);
    localparam logic [SW-1:0] SECTOR_LAST = SW'(SECTORS_PER_GROUP - 1);
    localparam logic [GW-1:0] GROUP_LAST  = GW'(NUM_GROUPS - 1);

    // Parameter sanity checks at elaboration time.
    if (NUM_GROUPS < 1) begin : g_bad_groups
        $error("NUM_GROUPS must be at least 1");
    end
    if (SECTORS_PER_GROUP < 1) begin : g_bad_sectors
        $error("SECTORS_PER_GROUP must be at least 1");
    end
    if (STEP_CYCLES < 1) begin : g_bad_step
        $error("STEP_CYCLES must be at least 1");
    end
    if (DONE_TIMEOUT < 1) begin : g_bad_timeout
        $error("DONE_TIMEOUT must be at least 1");
    end

    state_t        state;
    logic [TW-1:0] timer;

`ifdef SECTOR_DONE_TIMEOUT_EN
    localparam int TOW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [TOW-1:0] TO_LAST = TOW'(DONE_TIMEOUT - 1);
    logic [TOW-1:0] to_cnt;
`endif

    assign main_state = state;

    function automatic logic [SECTORS_PER_GROUP-1:0] onehot(
        input logic [SW-1:0] s
    );
        onehot    = '0;
        onehot[s] = 1'b1;
    endfunction

    function automatic logic [GW-1:0] next_group(
        input logic [GW-1:0] g
    );
        next_group = (g == GROUP_LAST) ? '0 : g + GW'(1);
    endfunction

    // Sequencer: state, dwell timer, indices and LED drive all move together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            group_idx  <= '0;
            sector_idx <= '0;
            led        <= '0;
            sweep_done <= 1'b0;
            timer      <= '0;
`ifdef SECTOR_DONE_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            sweep_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    led <= '0;
                    if (start && !abort) begin
                        state      <= S_SWEEP;
                        sector_idx <= '0;
                        timer      <= '0;
                        led        <= onehot('0);
                    end
                end

                S_SWEEP: begin
                    if (abort) begin
                        state      <= S_IDLE;
                        sector_idx <= '0;
                        timer      <= '0;
                        led        <= '0;
                    end else if (timer == STEP_LAST) begin
                        timer <= '0;
                        if (sector_idx == SECTOR_LAST) begin
                            state      <= S_DONE;
                            led        <= '1;
                            sweep_done <= 1'b1;
`ifdef SECTOR_DONE_TIMEOUT_EN
                            to_cnt     <= '0;
`endif
                        end else begin
                            sector_idx <= sector_idx + SW'(1);
                            led        <= onehot(sector_idx + SW'(1));
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                S_DONE: begin
                    led <= '1;
                    if (abort) begin
                        state      <= S_IDLE;
                        sector_idx <= '0;
                        timer      <= '0;
                        led        <= '0;
`ifdef SECTOR_DONE_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                    end else if (change_sector_group || start) begin
                        if (change_sector_group) begin
                            group_idx <= next_group(group_idx);
                        end
                        state      <= S_SWEEP;
                        sector_idx <= '0;
                        timer      <= '0;
                        led        <= onehot('0);
`ifdef SECTOR_DONE_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                    end
`ifdef SECTOR_DONE_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        state      <= S_IDLE;
                        sector_idx <= '0;
                        timer      <= '0;
                        led        <= '0;
                        to_cnt     <= '0;
                    end else begin
                        to_cnt <= to_cnt + TOW'(1);
                    end
`endif
                end

                default: begin
                    state      <= S_IDLE;
                    sector_idx <= '0;
                    timer      <= '0;
                    led        <= '0;
`ifdef SECTOR_DONE_TIMEOUT_EN
                    to_cnt     <= '0;
`endif
                end
            endcase
        end
    end

endmodule
